// File: rtl/kl8e_keyboard_pkg.sv
// Shared definitions for the KL8E console keyboard: serial timing defaults,
// receiver state encoding and device-03 IOT function codes.
package kl8e_keyboard_pkg;

  // System timing defaults; instantiations override through the top parameters.
  localparam int unsigned DEFAULT_CLOCK_FREQUENCY = 50_000_000;
  localparam int unsigned DEFAULT_BAUD_RATE       = 9600;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [2:0] IOT_OPCODE = 3'o6;
  localparam logic [5:0] KB_DEVICE  = 6'o03;

  localparam logic [2:0] KCF = 3'o0;
  localparam logic [2:0] KSF = 3'o1;
  localparam logic [2:0] KCC = 3'o2;
  localparam logic [2:0] KRS = 3'o4;
  localparam logic [2:0] KIE = 3'o5;
  localparam logic [2:0] KRB = 3'o6;

  // Bit period in clock cycles, rounded to nearest.
  function automatic int unsigned bit_period(input int unsigned freq,
                                             input int unsigned baud);
    return (freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/kl8e_keyboard_uart_rx_core.sv
// 8N1 serial receiver: rx synchronizer, bit timer, receive FSM and shift
// register. Emits the received byte with a one-cycle done pulse.
module uart_rx_core
  import kl8e_keyboard_pkg::*;
#(
  parameter int unsigned bitp = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [0:7] data,
  output logic       done
);

  localparam int unsigned TW = $clog2(bitp + 1);
  // Timer counts down to zero inclusive, so loading N-1 yields an N-cycle interval.
  localparam logic [TW-1:0] FULL_LOAD = TW'(bitp - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'((bitp / 2 > 0) ? (bitp / 2 - 1) : 0);

  logic rx_meta, rx_sync, rx_prev;

  rx_state_t     state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [0:7]    shift, shift_next;
  logic          frame_err, frame_err_next;
  logic          done_next;
  logic          expire;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= RX_IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      bit_cnt   <= bit_cnt_next;
      shift     <= shift_next;
      frame_err <= frame_err_next;
      done      <= done_next;
    end
  end

  assign expire = (timer == '0);

  always_comb begin
    state_next     = state;
    timer_next     = expire ? timer : timer - 1'b1;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift;
    frame_err_next = frame_err;
    done_next      = 1'b0;

    unique case (state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_next = RX_START;
          timer_next = HALF_LOAD;
        end
      end
      RX_START: begin
        if (expire) begin
          if (!rx_sync) begin
            state_next   = RX_DATA;
            timer_next   = FULL_LOAD;
            bit_cnt_next = '0;
          end else begin
            state_next = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (expire) begin
          // LSB arrives first and ends up at data[7] after eight shifts.
          shift_next   = {rx_sync, shift[0:6]};
          timer_next   = FULL_LOAD;
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (frame_err) begin
          if (rx_sync) begin
            state_next     = RX_IDLE;
            frame_err_next = 1'b0;
          end
        end else if (expire) begin
          if (rx_sync) begin
            done_next  = 1'b1;
            state_next = RX_IDLE;
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign data = shift;

endmodule

// File: rtl/kl8e_keyboard.sv
// KL8E console keyboard: character buffer, keyboard flag, interrupt enable
// and device-03 IOT decode around the serial receiver core.
module kl8e_keyboard
  import kl8e_keyboard_pkg::*;
#(
  parameter int unsigned clock_frequency = DEFAULT_CLOCK_FREQUENCY,
  parameter int unsigned baud_rate       = DEFAULT_BAUD_RATE
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx,
  input  logic [0:11] instruction,
  input  logic        iot_strobe,
  input  logic [0:11] ac_in,
  output logic        skip,
  output logic        clear_ac,
  output logic [0:11] or_ac,
  output logic        kb_flag,
  output logic        irq
);

  localparam int unsigned BITP = bit_period(clock_frequency, baud_rate);

  logic [0:7] rx_data;
  logic       rx_done;
  logic [0:7] buffer;
  logic       int_enable;
  logic       kb_iot;
  logic [2:0] fn;
  logic       flag_clear;
  logic       ie_load;

  uart_rx_core #(
    .bitp(BITP)
  ) u_core (
    .clk   (clk),
    .resetn(resetn),
    .rx    (rx),
    .data  (rx_data),
    .done  (rx_done)
  );

  assign kb_iot = iot_strobe && (instruction[0:2] == IOT_OPCODE)
                             && (instruction[3:8] == KB_DEVICE);
  assign fn     = instruction[9:11];

  always_comb begin
    skip       = 1'b0;
    clear_ac   = 1'b0;
    or_ac      = '0;
    flag_clear = 1'b0;
    ie_load    = 1'b0;
    if (kb_iot) begin
      unique case (fn)
        KCF: flag_clear = 1'b1;
        KSF: skip = kb_flag;
        KCC: begin
          clear_ac   = 1'b1;
          flag_clear = 1'b1;
        end
        KRS: or_ac = {4'b0000, buffer};
        KIE: ie_load = 1'b1;
        KRB: begin
          clear_ac   = 1'b1;
          or_ac      = {4'b0000, buffer};
          flag_clear = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A completing character takes priority over a clearing IOT in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buffer     <= '0;
      kb_flag    <= 1'b0;
      int_enable <= 1'b1;
    end else begin
      if (rx_done) begin
        buffer  <= rx_data;
        kb_flag <= 1'b1;
      end else if (flag_clear) begin
        kb_flag <= 1'b0;
      end
      if (ie_load) int_enable <= ac_in[11];
    end
  end

  assign irq = kb_flag & int_enable;

endmodule

// File: tb/tb_kl8e_keyboard.sv
// Directed bench for kl8e_keyboard at 16 clocks per serial bit.
module tb_kl8e_keyboard;

  localparam int unsigned BITP = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx;
  logic [0:11] instruction;
  logic        iot_strobe;
  logic [0:11] ac_in;
  logic        skip;
  logic        clear_ac;
  logic [0:11] or_ac;
  logic        kb_flag;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic        s, c;
  logic [11:0] o;
  logic        found;

  always #5 clk = ~clk;

  kl8e_keyboard #(
    .clock_frequency(16),
    .baud_rate      (1)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx         (rx),
    .instruction(instruction),
    .iot_strobe (iot_strobe),
    .ac_in      (ac_in),
    .skip       (skip),
    .clear_ac   (clear_ac),
    .or_ac      (or_ac),
    .kb_flag    (kb_flag),
    .irq        (irq)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    cycles(BITP);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cycles(BITP);
    end
    rx = stop;
    cycles(BITP);
    rx = 1'b1;
  endtask

  task automatic iot(input logic [11:0] ins, input logic [11:0] ac,
                     output logic sk, output logic cl, output logic [11:0] ov);
    instruction = ins;
    ac_in       = ac;
    iot_strobe  = 1'b1;
    #1;
    sk = skip;
    cl = clear_ac;
    ov = or_ac;
    @(posedge clk);
    #1;
    iot_strobe  = 1'b0;
    instruction = '0;
    ac_in       = '0;
  endtask

  initial begin
    resetn      = 1'b0;
    rx          = 1'b1;
    iot_strobe  = 1'b0;
    instruction = '0;
    ac_in       = '0;
    cycles(3);
    chk("rst_flag", kb_flag, 0);
    chk("rst_irq", irq, 0);
    chk("rst_skip", skip, 0);
    chk("rst_clear", clear_ac, 0);
    chk("rst_or", or_ac, 0);
    resetn = 1'b1;
    cycles(5);

    send(8'h41, 1'b1);
    cycles(2);
    chk("41_flag", kb_flag, 1);
    chk("41_irq", irq, 1);
    iot(12'o6034, 12'o0, s, c, o);
    chk("krs_or", o, 12'o0101);
    chk("krs_clear", c, 0);
    iot(12'o6031, 12'o0, s, c, o);
    chk("ksf_set", s, 1);
    iot(12'o6036, 12'o0, s, c, o);
    chk("krb_clear", c, 1);
    chk("krb_or", o, 12'o0101);
    chk("krb_flag", kb_flag, 0);
    iot(12'o6031, 12'o0, s, c, o);
    chk("ksf_clr", s, 0);
    chk("irq_clr", irq, 0);

    rx = 1'b0;
    cycles(BITP / 4);
    rx = 1'b1;
    cycles(40);
    chk("glitch_flag", kb_flag, 0);

    send(8'h55, 1'b0);
    cycles(20);
    chk("ferr_flag", kb_flag, 0);
    iot(12'o6034, 12'o0, s, c, o);
    chk("ferr_buf", o, 12'o0101);
    send(8'h0D, 1'b1);
    cycles(2);
    chk("0d_flag", kb_flag, 1);
    iot(12'o6034, 12'o0, s, c, o);
    chk("0d_buf", o, 12'o0015);

    instruction = 12'o6031;
    #1;
    chk("nostrobe_skip", skip, 0);
    instruction = '0;
    iot(12'o6131, 12'o0, s, c, o);
    chk("dev13_skip", s, 0);
    iot(12'o7031, 12'o0, s, c, o);
    chk("op7_skip", s, 0);
    iot(12'o6033, 12'o0, s, c, o);
    chk("6033_resp", {s, c, o[9:0]}, 12'o0);
    chk("6033_or", o, 12'o0);

    iot(12'o6035, 12'o0000, s, c, o);
    chk("kie0_irq", irq, 0);
    chk("kie0_flag", kb_flag, 1);
    iot(12'o6035, 12'o0001, s, c, o);
    chk("kie1_irq", irq, 1);

    iot(12'o6032, 12'o0, s, c, o);
    chk("kcc_clear", c, 1);
    chk("kcc_or", o, 12'o0);
    chk("kcc_flag", kb_flag, 0);

    found = 1'b0;
    fork
      send(8'h30, 1'b1);
      begin
        for (int i = 0; i < 400 && !found; i++) begin
          @(posedge clk);
          #1;
          if (dut.u_core.done) found = 1'b1;
        end
        if (found) iot(12'o6030, 12'o0, s, c, o);
      end
    join
    chk("done_seen", found, 1);
    chk("coinc_flag", kb_flag, 1);
    iot(12'o6030, 12'o0, s, c, o);
    chk("kcf_flag", kb_flag, 0);

    send(8'h31, 1'b1);
    cycles(2);
    chk("31_flag", kb_flag, 1);
    send(8'h32, 1'b1);
    cycles(2);
    chk("ovr_flag", kb_flag, 1);
    iot(12'o6034, 12'o0, s, c, o);
    chk("ovr_buf", o, 12'o0062);

    iot(12'o6035, 12'o0000, s, c, o);
    chk("pre_rst_irq", irq, 0);
    rx = 1'b0;
    cycles(BITP);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h22 >> i) & 1'b1;
      cycles(BITP);
    end
    rx = 1'b0;
    cycles(BITP / 2);
    resetn = 1'b0;
    #1;
    chk("mid_rst_flag", kb_flag, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_skip", skip, 0);
    chk("mid_rst_clear", clear_ac, 0);
    chk("mid_rst_or", or_ac, 0);
    rx = 1'b1;
    cycles(3);
    resetn = 1'b1;
    cycles(20);
    chk("post_rst_flag", kb_flag, 0);
    send(8'h7F, 1'b1);
    cycles(2);
    chk("7f_flag", kb_flag, 1);
    chk("7f_irq", irq, 1);
    iot(12'o6034, 12'o0, s, c, o);
    chk("7f_buf", o, 12'o0177);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
